// File: rtl/addsub_pkg.sv
// Shared encodings for the pipelined adder/subtractor: operation modes and flag bit positions.
// Helpers derive the B-operand inversion and carry-in from the mode.
package addsub_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ADC = 2'b10,
    MODE_SBC = 2'b11
  } mode_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // SUB and SBC both subtract, so bit 0 of the mode selects ~B.
  function automatic logic mode_inverts_b(input logic [1:0] m);
    return m[0];
  endfunction

  function automatic logic mode_carry_in(input logic [1:0] m, input logic cin);
    logic c;
    case (m)
      MODE_ADD: c = 1'b0;
      MODE_SUB: c = 1'b1;
      default:  c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit adder slice built from 4-bit carry-lookahead groups chained group to group.
// Zero latency, no flow control; exposes the carry into the MSB for overflow detection.
module cla_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  localparam int NG = W / 4;

  logic [W:0] w_c;

  assign w_c[0] = c;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_ci;

    assign w_g  = a[4*gi +: 4] & b[4*gi +: 4];
    assign w_p  = a[4*gi +: 4] ^ b[4*gi +: 4];
    assign w_ci = w_c[4*gi];

    assign w_c[4*gi+1] = w_g[0] | (w_p[0] & w_ci);
    assign w_c[4*gi+2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_ci);
    assign w_c[4*gi+3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                       | (w_p[2] & w_p[1] & w_p[0] & w_ci);
    assign w_c[4*gi+4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                       | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                       | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_ci);
  end

  assign s    = a ^ b ^ w_c[W-1:0];
  assign cout = w_c[W];
  assign cmsb = w_c[W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined ADD/SUB/ADC/SBC with NZCV flags; one operand slice resolved per stage, STAGES cycles latency.
// Whole pipeline stalls when the output beat is held (in_ready = !out_valid || out_ready).
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic [1:0]       mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int SW = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > 4 || (WIDTH % (4 * STAGES)) != 0) begin : g_bad_cfg
    $error("pipe_addsub: WIDTH must be a multiple of 4*STAGES with STAGES in 1..4");
  end

  // r_acc carries A forward; stage k overwrites slice k with its result bits.
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_acc [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic             r_c   [STAGES];
  logic [3:0]       r_flags;

  logic             w_in_vld [STAGES];
  logic [WIDTH-1:0] w_in_acc [STAGES];
  logic [WIDTH-1:0] w_in_b   [STAGES];
  logic             w_in_c   [STAGES];
  logic [WIDTH-1:0] w_nxt    [STAGES];
  logic [SW-1:0]    w_s      [STAGES];
  logic             w_co     [STAGES];
  logic             w_cm     [STAGES];

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  logic [3:0]       w_fl;

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign w_bx      = mode_inverts_b(mode) ? ~rb : rb;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_acc[STAGES-1];
  assign flags     = r_flags;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam logic [WIDTH-1:0] SLICE_MSK = {{(WIDTH-SW){1'b0}}, {SW{1'b1}}} << (k * SW);

    if (k == 0) begin : g_first
      assign w_in_vld[k] = in_valid;
      assign w_in_acc[k] = ra;
      assign w_in_b[k]   = w_bx;
      assign w_in_c[k]   = mode_carry_in(mode, cin);
    end else begin : g_next
      assign w_in_vld[k] = r_vld[k-1];
      assign w_in_acc[k] = r_acc[k-1];
      assign w_in_b[k]   = r_b[k-1];
      assign w_in_c[k]   = r_c[k-1];
    end

    cla_slice #(.W(SW)) u_cla (
      .a    (w_in_acc[k][k*SW +: SW]),
      .b    (w_in_b[k][k*SW +: SW]),
      .c    (w_in_c[k]),
      .s    (w_s[k]),
      .cout (w_co[k]),
      .cmsb (w_cm[k])
    );

    assign w_nxt[k] = (w_in_acc[k] & ~SLICE_MSK) | (WIDTH'(w_s[k]) << (k * SW));
  end

  // Overflow is carry-in vs carry-out of the MSB, equivalent to the sign-compare form.
  always_comb begin
    w_fl         = '0;
    w_fl[FLAG_N] = w_nxt[STAGES-1][WIDTH-1];
    w_fl[FLAG_Z] = (w_nxt[STAGES-1] == '0);
    w_fl[FLAG_C] = w_co[STAGES-1];
    w_fl[FLAG_V] = w_co[STAGES-1] ^ w_cm[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_acc[k] <= '0;
        r_b[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      r_flags <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_in_vld[k];
        r_acc[k] <= w_nxt[k];
        r_b[k]   <= w_in_b[k];
        r_c[k]   <= w_co[k];
      end
      r_flags <= w_fl;
    end
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning pipeline depth in register stages.
REQ-003 The block SHALL accept only WIDTH as a multiple of 4*STAGES, with STAGES in 1..4; any other value is an elaboration error.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port clr, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1: operand beat present.
REQ-007 Port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 Port ra, input, WIDTH: operand A.
REQ-009 Port rb, input, WIDTH: operand B.
REQ-010 Port mode, input, 2: 00 ADD, 01 SUB, 10 ADC (cin from port), 11 SBC (A - B - !cin).
REQ-011 Port cin, input, 1: carry in; used only in ADC/SBC.
REQ-012 Port out_valid, output, 1: result beat present.
REQ-013 Port out_ready, input, 1: downstream accepts a beat.
REQ-014 Port sum, output, WIDTH: result.
REQ-015 Port flags, output, 4: {N, Z, C, V}.

Function
REQ-016 The block SHALL transfer an input beat when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-017 The block SHALL compute sum = A + B' + c0, where B' = rb for ADD/ADC and ~rb for SUB/SBC; c0 = 0 for ADD, 1 for SUB, cin for ADC and SBC.
REQ-018 The block SHALL split the operands into STAGES equal slices; stage k SHALL add slice k using 4-bit carry-lookahead groups, registering the slice carry-out for stage k+1.
REQ-019 The block SHALL carry upper operand slices forward with the beat and register completed lower result slices, so each stage holds one beat.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, with no stall present.
REQ-021 Throughput SHALL be one beat per cycle while out_ready is held high.
REQ-022 The pipeline SHALL advance as a whole when advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-023 When advance is low, every stage register, including valid bits, SHALL hold its value.
REQ-024 When advance is high and a stage is empty, an empty beat SHALL propagate as a bubble with valid = 0.
REQ-025 C SHALL be the carry-out of the MSB: for SUB/SBC, C = 1 means no borrow.
REQ-026 V SHALL be (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
REQ-027 N SHALL be sum[MSB]; Z SHALL be (sum == 0).
REQ-028 sum and flags SHALL be stable and unchanged while out_valid && !out_ready.
REQ-029 in_valid with in_ready low SHALL NOT be captured; the source holds its beat until transfer.

Reset
REQ-030 When clr == 0 at a rising clk edge, all stage valid bits, out_valid, sum and flags SHALL become 0.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; no partial result SHALL appear afterwards.
REQ-032 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-033 The mode encodings and flag bit positions SHALL be defined in shared package addsub_pkg.
REQ-034 One combinational sub-module, cla_slice (parameter W, multiple of 4; inputs a, b, c; outputs s, cout, plus the MSB carry-in for V), SHALL be instantiated once per stage.

Verification
REQ-035 With WIDTH=32, STAGES=2: ADD 0x0000_0005 + 0x0000_0003 -> sum 0x0000_0008, flags 0000, out_valid exactly 2 cycles after transfer.
REQ-036 ADD 0xFFFF_FFFF + 0x0000_0001 -> sum 0, flags Z=1 C=1 N=0 V=0; also checks carry crossing the stage boundary at bit 16.
REQ-037 SUB 0x8000_0000 - 0x0000_0001 -> sum 0x7FFF_FFFF, V=1 C=1 N=0; ADC with 0x7FFF_FFFF + 0 and cin=1 -> sum 0x8000_0000, V=1 N=1.
REQ-038 Stream 8 back-to-back beats; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, output held stable, all 8 results in order with none lost or duplicated.
REQ-039 Drive clr=0 with 2 beats in flight -> out_valid=0 next cycle, and no stale result after release.
REQ-040 Repeat REQ-035..REQ-038 with WIDTH=16, STAGES=4 and WIDTH=8, STAGES=1, with latencies of 4 and 1 cycles respectively.
